// File: rtl/hdmi_sync_pkg.sv
// Shared definitions for the HDMI bit-slip scan controller.
// Contents: TMDS control tokens, slip word geometry, channel FSM states.
package hdmi_sync_pkg;

  // The four TMDS control-period symbols (C1,C0 = 00,01,10,11)
  localparam logic [9:0] CTL0 = 10'h354;
  localparam logic [9:0] CTL1 = 10'h0ab;
  localparam logic [9:0] CTL2 = 10'h154;
  localparam logic [9:0] CTL3 = 10'h2ab;

  // Manual bitslip word: bit 4 = locked, bits [3:0] = slip position
  localparam int SLIP_W   = 5;
  localparam int SLIP_MOD = 10;

  typedef enum logic [1:0] {
    S_SETTLE,
    S_MEASURE,
    S_LOCKED
  } chan_state_t;

  // True when a slipped 10-bit word is one of the control tokens
  function automatic logic is_ctl_token(input logic [9:0] word);
    return (word == CTL0) || (word == CTL1) || (word == CTL2) || (word == CTL3);
  endfunction

endpackage

// File: rtl/hdmi_slip_chan.sv
// One TMDS channel of the bit-slip scanner: steps the slip position,
// scores each position by counting control tokens over a window,
// holds the first passing position and re-scans when tokens disappear.
// Optional feature macro: HDMI_SLIP_SCAN_SCORE_EN (exposes window end/count).
module hdmi_slip_chan
  import hdmi_sync_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int WINDOW_CYCLES = 4096,
  parameter int MIN_TOKENS    = 64,
  parameter int LOSS_CYCLES   = 16384
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              restart,
  input  logic [9:0]        word,
  output logic [SLIP_W-1:0] bitslip,
  output logic              sweep_fail
`ifdef HDMI_SLIP_SCAN_SCORE_EN
  ,
  output logic              win_end,
  output logic [15:0]       win_count
`endif
);

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] WINDOW_LAST = 16'(WINDOW_CYCLES - 1);
  localparam logic [15:0] LOSS_LAST   = 16'(LOSS_CYCLES - 1);
  localparam logic [15:0] MIN_TOK     = 16'(MIN_TOKENS);
  localparam logic [3:0]  SLIP_LAST   = 4'(SLIP_MOD - 1);

  chan_state_t state, state_n;
  logic [15:0] timer, timer_n;
  logic [15:0] count, count_n;
  logic [3:0]  slip, slip_n;
  logic [3:0]  fail_cnt, fail_n;
  logic        locked, locked_n;
  logic        sweep, sweep_n;

  logic        token;
  logic [15:0] count_sat;
  logic [15:0] window_total;
  logic [3:0]  slip_adv;

  assign token        = is_ctl_token(word);
  assign count_sat    = (count == 16'hffff) ? count : count + 16'd1;
  assign window_total = token ? count_sat : count;
  assign slip_adv     = (slip == SLIP_LAST) ? 4'd0 : slip + 4'd1;

  assign bitslip    = {locked, slip};
  assign sweep_fail = sweep;

`ifdef HDMI_SLIP_SCAN_SCORE_EN
  // A window only counts as finished when neither disable nor restart overrides it
  assign win_end   = enable && !restart && (state == S_MEASURE) && (timer == WINDOW_LAST);
  assign win_count = window_total;
`endif

  // Next-state logic: disable beats restart, restart beats the normal scan
  always_comb begin
    state_n  = state;
    timer_n  = timer;
    count_n  = count;
    slip_n   = slip;
    fail_n   = fail_cnt;
    locked_n = locked;
    sweep_n  = 1'b0;

    if (!enable) begin
      state_n  = S_SETTLE;
      timer_n  = 16'd0;
      locked_n = 1'b0;
    end else if (restart) begin
      state_n  = S_SETTLE;
      timer_n  = 16'd0;
      slip_n   = 4'd0;
      locked_n = 1'b0;
      fail_n   = 4'd0;
    end else begin
      case (state)
        S_SETTLE: begin
          if (timer == SETTLE_LAST) begin
            state_n = S_MEASURE;
            timer_n = 16'd0;
            count_n = 16'd0;
          end else begin
            timer_n = timer + 16'd1;
          end
        end

        S_MEASURE: begin
          count_n = window_total;
          timer_n = timer + 16'd1;
          if (timer == WINDOW_LAST) begin
            timer_n = 16'd0;
            if (window_total >= MIN_TOK) begin
              state_n = S_LOCKED;
              fail_n  = 4'd0;
            end else begin
              state_n = S_SETTLE;
              slip_n  = slip_adv;
              if (fail_cnt == SLIP_LAST) begin
                fail_n  = 4'd0;
                sweep_n = 1'b1;
              end else begin
                fail_n = fail_cnt + 4'd1;
              end
            end
          end
        end

        S_LOCKED: begin
          locked_n = 1'b1;
          if (token) begin
            timer_n = 16'd0;
          end else if (timer == LOSS_LAST) begin
            locked_n = 1'b0;
            slip_n   = slip_adv;
            state_n  = S_SETTLE;
            timer_n  = 16'd0;
          end else begin
            timer_n = timer + 16'd1;
          end
        end

        default: begin
          state_n  = S_SETTLE;
          timer_n  = 16'd0;
          locked_n = 1'b0;
        end
      endcase
    end
  end

  // State register; reset abandons any scan in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_SETTLE;
      timer    <= 16'd0;
      count    <= 16'd0;
      slip     <= 4'd0;
      fail_cnt <= 4'd0;
      locked   <= 1'b0;
      sweep    <= 1'b0;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      count    <= count_n;
      slip     <= slip_n;
      fail_cnt <= fail_n;
      locked   <= locked_n;
      sweep    <= sweep_n;
    end
  end

endmodule

// File: rtl/hdmi_slip_scan.sv
// Automatic bit-slip scan controller for the R, G and B TMDS channels.
// Runs in the pixel clock domain and drives the sync stage's manual slips.
// o_sweep_fail bit order: [0] red, [1] green, [2] blue.
// Optional feature macro: HDMI_SLIP_SCAN_SCORE_EN adds o_score, the last
// completed red window token count.
module hdmi_slip_scan
  import hdmi_sync_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int WINDOW_CYCLES = 4096,
  parameter int MIN_TOKENS    = 64,
  parameter int LOSS_CYCLES   = 16384
) (
  input  logic              i_pix_clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_restart,
  input  logic [9:0]        i_r,
  input  logic [9:0]        i_g,
  input  logic [9:0]        i_b,
  output logic [SLIP_W-1:0] o_bitslip_r,
  output logic [SLIP_W-1:0] o_bitslip_g,
  output logic [SLIP_W-1:0] o_bitslip_b,
  output logic              o_all_locked,
  output logic [2:0]        o_sweep_fail
`ifdef HDMI_SLIP_SCAN_SCORE_EN
  ,
  output logic [15:0]       o_score
`endif
);

`ifdef HDMI_SLIP_SCAN_SCORE_EN
  logic        red_win_end;
  logic [15:0] red_win_count;
`endif

  hdmi_slip_chan #(
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .WINDOW_CYCLES(WINDOW_CYCLES),
    .MIN_TOKENS   (MIN_TOKENS),
    .LOSS_CYCLES  (LOSS_CYCLES)
  ) u_chan_r (
    .clk       (i_pix_clk),
    .rst       (i_reset),
    .enable    (i_enable),
    .restart   (i_restart),
    .word      (i_r),
    .bitslip   (o_bitslip_r),
    .sweep_fail(o_sweep_fail[0])
`ifdef HDMI_SLIP_SCAN_SCORE_EN
    ,
    .win_end   (red_win_end),
    .win_count (red_win_count)
`endif
  );

  hdmi_slip_chan #(
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .WINDOW_CYCLES(WINDOW_CYCLES),
    .MIN_TOKENS   (MIN_TOKENS),
    .LOSS_CYCLES  (LOSS_CYCLES)
  ) u_chan_g (
    .clk       (i_pix_clk),
    .rst       (i_reset),
    .enable    (i_enable),
    .restart   (i_restart),
    .word      (i_g),
    .bitslip   (o_bitslip_g),
    .sweep_fail(o_sweep_fail[1])
`ifdef HDMI_SLIP_SCAN_SCORE_EN
    ,
    .win_end   (),
    .win_count ()
`endif
  );

  hdmi_slip_chan #(
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .WINDOW_CYCLES(WINDOW_CYCLES),
    .MIN_TOKENS   (MIN_TOKENS),
    .LOSS_CYCLES  (LOSS_CYCLES)
  ) u_chan_b (
    .clk       (i_pix_clk),
    .rst       (i_reset),
    .enable    (i_enable),
    .restart   (i_restart),
    .word      (i_b),
    .bitslip   (o_bitslip_b),
    .sweep_fail(o_sweep_fail[2])
`ifdef HDMI_SLIP_SCAN_SCORE_EN
    ,
    .win_end   (),
    .win_count ()
`endif
  );

  // Registered AND of the three locked bits, one cycle behind the slips
  always_ff @(posedge i_pix_clk or posedge i_reset) begin
    if (i_reset) begin
      o_all_locked <= 1'b0;
    end else begin
      o_all_locked <= o_bitslip_r[SLIP_W-1] & o_bitslip_g[SLIP_W-1] & o_bitslip_b[SLIP_W-1];
    end
  end

`ifdef HDMI_SLIP_SCAN_SCORE_EN
  // Capture the red channel's final window count for eye-quality display
  always_ff @(posedge i_pix_clk or posedge i_reset) begin
    if (i_reset) begin
      o_score <= 16'd0;
    end else if (red_win_end) begin
      o_score <= red_win_count;
    end
  end
`endif

endmodule

// File: tb/tb_hdmi_slip_scan.sv
// Directed testbench for hdmi_slip_scan with small timing parameters
// (settle 4, window 32, min tokens 8, loss 64). A small sync-stage model
// feeds tokens back depending on the slip the DUT currently requests.
module tb_hdmi_slip_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        restart = 1'b0;
  logic [9:0]  word_r = 10'h000;
  logic [9:0]  word_g = 10'h000;
  logic [9:0]  word_b = 10'h000;
  logic [4:0]  bitslip_r, bitslip_g, bitslip_b;
  logic        all_locked;
  logic [2:0]  sweep_fail;
`ifdef HDMI_SLIP_SCAN_SCORE_EN
  logic [15:0] score;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus model state
  int         mode = 0;        // 0: tokens at good_slip, 1: random non-token, 2: scripted cycles
  int         good_slip = 3;
  logic [2:0] tok_en = 3'b111; // [0] r, [1] g, [2] b
  int         cyc = 0;
  int         sweep_cnt[3];
  bit         all_locked_seen;
  logic [14:0] bs_all;

  hdmi_slip_scan #(
    .SETTLE_CYCLES(4),
    .WINDOW_CYCLES(32),
    .MIN_TOKENS   (8),
    .LOSS_CYCLES  (64)
  ) dut (
    .i_pix_clk   (clk),
    .i_reset     (rst),
    .i_enable    (enable),
    .i_restart   (restart),
    .i_r         (word_r),
    .i_g         (word_g),
    .i_b         (word_b),
    .o_bitslip_r (bitslip_r),
    .o_bitslip_g (bitslip_g),
    .o_bitslip_b (bitslip_b),
    .o_all_locked(all_locked),
    .o_sweep_fail(sweep_fail)
`ifdef HDMI_SLIP_SCAN_SCORE_EN
    ,
    .o_score     (score)
`endif
  );

  // Free-running pixel clock
  always #5 clk = ~clk;

  function automatic logic [9:0] gen_word(input int ch, input logic [4:0] bs);
    logic [9:0] tok;
    logic [9:0] w;
    tok = (ch == 0) ? 10'h354 : (ch == 1) ? 10'h0ab : 10'h154;
    w   = 10'h000;
    case (mode)
      0: if (tok_en[ch] && (int'(bs[3:0]) == good_slip)) w = tok;
      1: begin
        w = 10'($urandom_range(0, 1023));
        if (w == 10'h354 || w == 10'h0ab || w == 10'h154 || w == 10'h2ab) w = w ^ 10'h001;
      end
      2: if ((cyc <= 3) || (cyc >= 29 && cyc <= 35) || (cyc >= 64 && cyc <= 71)) w = tok;
      default: w = 10'h000;
    endcase
    return w;
  endfunction

  // Drive n cycles of words, ending at a falling edge after n rising edges
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      word_r = gen_word(0, bitslip_r);
      word_g = gen_word(1, bitslip_g);
      word_b = gen_word(2, bitslip_b);
      @(negedge clk);
      cyc++;
      for (int c = 0; c < 3; c++) if (sweep_fail[c]) sweep_cnt[c]++;
      if (all_locked) all_locked_seen = 1'b1;
      bs_all = {bitslip_r, bitslip_g, bitslip_b};
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    restart = 1'b0;
    enable  = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bitslip_r, bitslip_g, bitslip_b, all_locked, sweep_fail} !== 19'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_state: got %h expected 0",
               {bitslip_r, bitslip_g, bitslip_b, all_locked, sweep_fail});
    end
  endtask

  task automatic test_lock_scan();
    mode = 0; good_slip = 3; tok_en = 3'b111;
    do_reset();
    run(36);
    n_checks++;
    if (bs_all !== {3{5'h01}}) begin n_fail++; $display("[TB] FAIL scan_first_fail: got %h expected %h", bs_all, {3{5'h01}}); end
    run(108);
    n_checks++;
    if (bs_all !== {3{5'h03}}) begin n_fail++; $display("[TB] FAIL scan_before_lock: got %h expected %h", bs_all, {3{5'h03}}); end
    run(1);
    n_checks++;
    if (bs_all !== {3{5'h13}}) begin n_fail++; $display("[TB] FAIL scan_lock: got %h expected %h", bs_all, {3{5'h13}}); end
    n_checks++;
    if (all_locked !== 1'b0) begin n_fail++; $display("[TB] FAIL scan_all_locked_early: got %b expected 0", all_locked); end
    run(1);
    n_checks++;
    if (all_locked !== 1'b1) begin n_fail++; $display("[TB] FAIL scan_all_locked: got %b expected 1", all_locked); end
  endtask

  task automatic test_sweep();
    mode = 1;
    do_reset();
    run(359);
    n_checks++;
    if ({bs_all, sweep_fail} !== {{3{5'h09}}, 3'b000}) begin
      n_fail++; $display("[TB] FAIL sweep_slip9: got %h expected %h", {bs_all, sweep_fail}, {{3{5'h09}}, 3'b000});
    end
    run(1);
    n_checks++;
    if ({bs_all, sweep_fail} !== {{3{5'h00}}, 3'b111}) begin
      n_fail++; $display("[TB] FAIL sweep_pulse_wrap: got %h expected %h", {bs_all, sweep_fail}, {{3{5'h00}}, 3'b111});
    end
    run(1);
    n_checks++;
    if (sweep_fail !== 3'b000) begin n_fail++; $display("[TB] FAIL sweep_pulse_width: got %b expected 000", sweep_fail); end
    for (int c = 0; c < 3; c++) sweep_cnt[c] = 0;
    all_locked_seen = 1'b0;
    run(359);
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (sweep_cnt[c] != 1) begin n_fail++; $display("[TB] FAIL sweep_count_ch%0d: got %0d expected 1", c, sweep_cnt[c]); end
    end
    n_checks++;
    if (all_locked_seen !== 1'b0) begin n_fail++; $display("[TB] FAIL sweep_no_lock: got %b expected 0", all_locked_seen); end
  endtask

  task automatic test_loss_green();
    mode = 0; good_slip = 3; tok_en = 3'b111;
    do_reset();
    run(146);
    tok_en = 3'b101;
    run(63);
    n_checks++;
    if (bs_all !== {3{5'h13}}) begin n_fail++; $display("[TB] FAIL loss_hold: got %h expected %h", bs_all, {3{5'h13}}); end
    run(1);
    n_checks++;
    if (bs_all !== {5'h13, 5'h04, 5'h13}) begin n_fail++; $display("[TB] FAIL loss_green: got %h expected %h", bs_all, {5'h13, 5'h04, 5'h13}); end
    run(1);
    n_checks++;
    if (all_locked !== 1'b0) begin n_fail++; $display("[TB] FAIL loss_all_locked: got %b expected 0", all_locked); end
  endtask

  task automatic test_window_boundary();
    mode = 2;
    do_reset();
    run(36);
    n_checks++;
    if (bs_all !== {3{5'h01}}) begin n_fail++; $display("[TB] FAIL bound_7_fails: got %h expected %h", bs_all, {3{5'h01}}); end
    run(36);
    n_checks++;
    if (bs_all !== {3{5'h01}}) begin n_fail++; $display("[TB] FAIL bound_before_lock: got %h expected %h", bs_all, {3{5'h01}}); end
    run(1);
    n_checks++;
    if (bs_all !== {3{5'h11}}) begin n_fail++; $display("[TB] FAIL bound_8_passes: got %h expected %h", bs_all, {3{5'h11}}); end
  endtask

  task automatic test_restart();
    mode = 0; good_slip = 3; tok_en = 3'b111;
    do_reset();
    run(146);
    restart = 1'b1;
    run(1);
    restart = 1'b0;
    n_checks++;
    if (bs_all !== {3{5'h00}}) begin n_fail++; $display("[TB] FAIL restart_clear: got %h expected %h", bs_all, {3{5'h00}}); end
    run(1);
    n_checks++;
    if (all_locked !== 1'b0) begin n_fail++; $display("[TB] FAIL restart_all_locked: got %b expected 0", all_locked); end
    run(143);
    n_checks++;
    if (bs_all !== {3{5'h03}}) begin n_fail++; $display("[TB] FAIL restart_rescan: got %h expected %h", bs_all, {3{5'h03}}); end
    run(1);
    n_checks++;
    if (bs_all !== {3{5'h13}}) begin n_fail++; $display("[TB] FAIL restart_relock: got %h expected %h", bs_all, {3{5'h13}}); end
  endtask

  task automatic test_restart_window_end();
    mode = 0; good_slip = 0; tok_en = 3'b111;
    do_reset();
    run(35);
    restart = 1'b1;
    run(1);
    restart = 1'b0;
    run(1);
    n_checks++;
    if (bs_all !== {3{5'h00}}) begin n_fail++; $display("[TB] FAIL restart_discard: got %h expected %h", bs_all, {3{5'h00}}); end
    run(36);
    n_checks++;
    if (bs_all !== {3{5'h10}}) begin n_fail++; $display("[TB] FAIL restart_discard_relock: got %h expected %h", bs_all, {3{5'h10}}); end
  endtask

  task automatic test_enable_reset();
    mode = 0; good_slip = 3; tok_en = 3'b111;
    do_reset();
    run(146);
    enable = 1'b0;
    run(1);
    n_checks++;
    if (bs_all !== {3{5'h03}}) begin n_fail++; $display("[TB] FAIL disable_unlock: got %h expected %h", bs_all, {3{5'h03}}); end
    run(5);
    n_checks++;
    if ({bs_all, all_locked} !== {{3{5'h03}}, 1'b0}) begin
      n_fail++; $display("[TB] FAIL disable_hold: got %h expected %h", {bs_all, all_locked}, {{3{5'h03}}, 1'b0});
    end
    enable = 1'b1;
    run(20);
    n_checks++;
    if (bs_all !== {3{5'h03}}) begin n_fail++; $display("[TB] FAIL reenable_midwindow: got %h expected %h", bs_all, {3{5'h03}}); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({bitslip_r, bitslip_g, bitslip_b, all_locked, sweep_fail} !== 19'h0) begin
      n_fail++; $display("[TB] FAIL async_reset: got %h expected 0",
                         {bitslip_r, bitslip_g, bitslip_b, all_locked, sweep_fail});
    end
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    run(36);
    n_checks++;
    if (bs_all !== {3{5'h01}}) begin n_fail++; $display("[TB] FAIL reset_rescan: got %h expected %h", bs_all, {3{5'h01}}); end
  endtask

  // Test sequence
  initial begin
    for (int c = 0; c < 3; c++) sweep_cnt[c] = 0;
    all_locked_seen = 1'b0;
    bs_all = 15'h0;
    test_reset();
    test_lock_scan();
    test_sweep();
    test_loss_green();
    test_window_boundary();
    test_restart();
    test_restart_window_end();
    test_enable_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
